// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: debounced key commands, IDLE/RUN/PAUSE FSM,
// centisecond counter, display register and lap buffer with recall.
module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned MAX_TIME        = 359999,
   parameter int unsigned LAPS            = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      key3,
   input  logic                      key2,
   input  logic                      key1,
   input  logic                      key0,
   input  logic                      tick,
   output logic [18:0]               time_counter,
   output logic [18:0]               time_display,
   output logic                      counting,
   output logic                      paused,
   output logic                      frozen,
   output logic [$clog2(LAPS):0]     lap_count,
   output logic [$clog2(LAPS)-1:0]   recall_idx
);

   localparam int unsigned IdxW = $clog2(LAPS);
   localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   // Key path: synchronize, debounce, detect accepted 1->0 edge.
   logic [3:0]     keys_raw;
   logic [3:0]     sync1_q, sync2_q, level_q, level_d, press_q;
   logic [DbW-1:0] db_cnt_q [4];
   logic [DbW-1:0] db_cnt_d [4];

   assign keys_raw = {key3, key2, key1, key0};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         level_d[i]  = level_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         level_q <= '1;
         press_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= keys_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= level_q & ~level_d;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   // Only the highest-priority event of a cycle survives.
   logic ev3, ev2, ev1, ev0;
   assign ev3 = press_q[3];
   assign ev2 = press_q[2] & ~press_q[3];
   assign ev1 = press_q[1] & ~|press_q[3:2];
   assign ev0 = press_q[0] & ~|press_q[3:1];

   state_e          state_q, state_d;
   logic [18:0]     cnt_q, cnt_d, disp_q, disp_d, cnt_inc;
   logic            frozen_q, frozen_d;
   logic [IdxW:0]   lap_cnt_q, lap_cnt_d, recall_ext;
   logic [IdxW-1:0] recall_q, recall_d;
   logic            lap_we;
   logic [18:0]     lap_mem [LAPS];

   assign cnt_inc    = (cnt_q == 19'(MAX_TIME)) ? '0 : cnt_q + 19'd1;
   assign recall_ext = {1'b0, recall_q} + (IdxW + 1)'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      disp_d    = disp_q;
      frozen_d  = frozen_q;
      lap_cnt_d = lap_cnt_q;
      recall_d  = recall_q;
      lap_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ev3) begin
               state_d  = StRun;
               cnt_d    = '0;
               frozen_d = 1'b0;
            end else if (ev1 && lap_cnt_q != '0) begin
               disp_d   = lap_mem[recall_q];
               recall_d = (recall_ext >= lap_cnt_q) ? '0 : recall_ext[IdxW-1:0];
            end else if (ev0) begin
               lap_cnt_d = '0;
               recall_d  = '0;
               disp_d    = '0;
            end
         end
         StRun: begin
            if (ev3) begin
               state_d  = StIdle;
               cnt_d    = '0;
               disp_d   = '0;
               frozen_d = 1'b0;
               recall_d = '0;
            end else if (ev2) begin
               state_d = StPause;
            end else begin
               if (tick) begin
                  cnt_d = cnt_inc;
                  if (!frozen_q) disp_d = cnt_inc;
               end
               // Lap shows the pre-increment value even when a tick lands on it.
               if (ev1) begin
                  frozen_d = 1'b1;
                  disp_d   = cnt_q;
                  if (lap_cnt_q < (IdxW + 1)'(LAPS)) begin
                     lap_we    = 1'b1;
                     lap_cnt_d = lap_cnt_q + (IdxW + 1)'(1);
                  end
               end else if (ev0) begin
                  frozen_d = 1'b0;
                  disp_d   = cnt_d;
               end
            end
         end
         StPause: begin
            if (ev3) begin
               state_d  = StIdle;
               cnt_d    = '0;
               disp_d   = '0;
               frozen_d = 1'b0;
               recall_d = '0;
            end else if (ev2) begin
               state_d = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         disp_q    <= '0;
         frozen_q  <= 1'b0;
         lap_cnt_q <= '0;
         recall_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         disp_q    <= disp_d;
         frozen_q  <= frozen_d;
         lap_cnt_q <= lap_cnt_d;
         recall_q  <= recall_d;
      end
   end

   // Lap storage needs no reset: entries beyond lap_count are never read.
   always_ff @(posedge clk) begin
      if (lap_we) lap_mem[lap_cnt_q[IdxW-1:0]] <= cnt_q;
   end

   assign time_counter = cnt_q;
   assign time_display = disp_q;
   assign counting     = (state_q != StIdle);
   assign paused       = (state_q == StPause);
   assign frozen       = frozen_q;
   assign lap_count    = lap_cnt_q;
   assign recall_idx   = recall_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios followed by random key/tick
// traffic, all checked against a command-level behavioural model.
module tb_stopwatch_ctrl;

   localparam int unsigned DB    = 4;
   localparam int unsigned MAXT  = 999;
   localparam int unsigned NLAPS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        key3, key2, key1, key0, tick;
   logic [18:0] time_counter, time_display;
   logic        counting, paused, frozen;
   logic [3:0]  lap_count;
   logic [2:0]  recall_idx;

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .MAX_TIME        (MAXT),
      .LAPS            (NLAPS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key3         (key3),
      .key2         (key2),
      .key1         (key1),
      .key0         (key0),
      .tick         (tick),
      .time_counter (time_counter),
      .time_display (time_display),
      .counting     (counting),
      .paused       (paused),
      .frozen       (frozen),
      .lap_count    (lap_count),
      .recall_idx   (recall_idx)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model: state as plain flags, laps as a queue.
   bit m_run, m_pause, m_frozen;
   int m_cnt, m_disp, m_recall;
   int m_laps[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".counter"},  32'(time_counter), 32'(m_cnt));
      chk({tag, ".display"},  32'(time_display), 32'(m_disp));
      chk({tag, ".counting"}, 32'(counting),     32'(m_run));
      chk({tag, ".paused"},   32'(paused),       32'(m_pause));
      chk({tag, ".frozen"},   32'(frozen),       32'(m_frozen));
      chk({tag, ".laps"},     32'(lap_count),    32'(m_laps.size()));
      chk({tag, ".recall"},   32'(recall_idx),   32'(m_recall));
   endtask

   function automatic void m_reset();
      m_run = 0; m_pause = 0; m_frozen = 0;
      m_cnt = 0; m_disp = 0; m_recall = 0;
      m_laps.delete();
   endfunction

   function automatic void m_tick();
      if (m_run && !m_pause) begin
         m_cnt = (m_cnt == int'(MAXT)) ? 0 : m_cnt + 1;
         if (!m_frozen) m_disp = m_cnt;
      end
   endfunction

   function automatic void m_key(input int k);
      if (!m_run) begin
         if (k == 3) begin
            m_run = 1; m_cnt = 0; m_frozen = 0;
         end else if (k == 1 && m_laps.size() > 0) begin
            m_disp   = m_laps[m_recall];
            m_recall = (m_recall + 1) % m_laps.size();
         end else if (k == 0) begin
            m_laps.delete(); m_recall = 0; m_disp = 0;
         end
      end else if (k == 3) begin
         m_run = 0; m_pause = 0; m_cnt = 0; m_disp = 0; m_frozen = 0; m_recall = 0;
      end else if (k == 2) begin
         m_pause = !m_pause;
      end else if (!m_pause && k == 1) begin
         m_frozen = 1; m_disp = m_cnt;
         if (m_laps.size() < int'(NLAPS)) m_laps.push_back(m_cnt);
      end else if (!m_pause && k == 0) begin
         m_frozen = 0; m_disp = m_cnt;
      end
   endfunction

   function automatic int highest(input logic [3:0] mask);
      for (int i = 3; i >= 0; i--) if (mask[i]) return i;
      return -1;
   endfunction

   task automatic set_keys(input logic [3:0] mask);
      {key3, key2, key1, key0} = ~mask;
   endtask

   // Hold keys until the event is acted on (2 + DB + 1 edges), optionally with
   // a tick on that same edge, then release and let the release settle.
   task automatic press(input logic [3:0] mask, input bit with_tick);
      bit was_run;
      int k;
      @(negedge clk);
      set_keys(mask);
      repeat (DB + 2) @(negedge clk);
      if (with_tick) tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      set_keys(4'b0000);
      was_run = m_run && !m_pause;
      k = highest(mask);
      if (k >= 0) m_key(k);
      if (with_tick && was_run && k < 2) m_tick();
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      if (n > 0) begin
         tick = 1'b1;
         repeat (n) @(negedge clk);
         tick = 1'b0;
         repeat (n) m_tick();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_keys(4'b0000);
      tick = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      @(negedge clk);

      // Start latency: counting rises exactly on the 7th edge after key3 low.
      key3 = 1'b0;
      repeat (6) @(negedge clk);
      chk("lat.edge6", 32'(counting), 32'd0);
      @(negedge clk);
      chk("lat.edge7", 32'(counting), 32'd1);
      key3 = 1'b1;
      m_key(3);
      repeat (DB + 4) @(negedge clk);
      ticks(250);
      chk("run250.counter", 32'(time_counter), 32'd250);
      chk("run250.display", 32'(time_display), 32'd250);
      check_all("run250");

      // Pause / resume, with tick coinciding with the pause press.
      press(4'b1000, 0);
      press(4'b1000, 0);
      ticks(100);
      press(4'b0100, 1);
      chk("pause.counter", 32'(time_counter), 32'd100);
      check_all("pause");
      ticks(50);
      chk("pause50.counter", 32'(time_counter), 32'd100);
      press(4'b0100, 0);
      ticks(1);
      chk("resume.counter", 32'(time_counter), 32'd101);
      check_all("resume");

      // Laps at 120, 340, 777 from a clean buffer.
      press(4'b1000, 0);
      press(4'b0001, 0);
      press(4'b1000, 0);
      ticks(120); press(4'b0010, 0);
      ticks(220); press(4'b0010, 0);
      ticks(437); press(4'b0010, 0);
      ticks(50);
      chk("laps.display", 32'(time_display), 32'd777);
      chk("laps.count",   32'(lap_count),    32'd3);
      check_all("laps");
      press(4'b0001, 0);
      check_all("unfreeze");

      // Recall in IDLE, wrapping after the last lap; then clear.
      press(4'b1000, 0);
      press(4'b0010, 0); chk("recall0", 32'(time_display), 32'd120);
      press(4'b0010, 0); chk("recall1", 32'(time_display), 32'd340);
      press(4'b0010, 0); chk("recall2", 32'(time_display), 32'd777);
      press(4'b0010, 0); chk("recall3", 32'(time_display), 32'd120);
      check_all("recall");
      press(4'b0001, 0);
      check_all("clear");

      // Bouncing key3 gives nothing until it settles, then exactly one start.
      for (int i = 0; i < 10; i++) begin
         key3 = 1'(i % 2);
         repeat (2) @(negedge clk);
      end
      chk("bounce.idle", 32'(counting), 32'd0);
      key3 = 1'b0;
      repeat (DB + 3) @(negedge clk);
      key3 = 1'b1;
      m_key(3);
      repeat (DB + 4) @(negedge clk);
      check_all("bounce");

      // Short glitch on key2 while running is ignored.
      ticks(5);
      key2 = 1'b0;
      repeat (3) @(negedge clk);
      key2 = 1'b1;
      repeat (DB + 6) @(negedge clk);
      check_all("glitch");

      // Nine captures into an eight-entry buffer; one lands on a tick.
      for (int i = 0; i < 9; i++) begin
         ticks(3);
         press(4'b0010, i == 4);
      end
      chk("full.count", 32'(lap_count), 32'd8);
      check_all("full");

      // Simultaneous key3+key1 in RUN: only the stop is acted on.
      press(4'b1010, 0);
      check_all("prio");

      // Wrap with a frozen display, then asynchronous reset mid-run.
      press(4'b1000, 0);
      ticks(990);
      press(4'b0010, 0);
      ticks(9);
      chk("wrap.max", 32'(time_counter), 32'(MAXT));
      ticks(1);
      chk("wrap.zero",   32'(time_counter), 32'd0);
      chk("wrap.frozen", 32'(frozen),       32'd1);
      chk("wrap.disp",   32'(time_display), 32'd990);
      check_all("wrap");
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Random traffic against the model.
      for (int r = 0; r < 80; r++) begin
         int sel;
         logic [3:0] mask;
         ticks(int'($urandom_range(0, 25)));
         sel  = int'($urandom_range(0, 9));
         mask = (sel < 8) ? 4'(1 << (sel % 4)) : 4'($urandom_range(1, 15));
         press(mask, 1'($urandom_range(0, 1)));
         check_all("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
